// File: rtl/decode_stage.sv
// RISC-8 instruction-decode stage: cracks the IF/ID instruction, drives register
// file read addresses, detects load-use hazards and fills the ID/EX register.
module decode_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic [7:0]  id_pc,
  input  logic        flush,
  output logic [2:0]  ra1,
  output logic [2:0]  ra2,
  input  logic [7:0]  rd1,
  input  logic [7:0]  rd2,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_op,
  output logic [7:0]  ex_a,
  output logic [7:0]  ex_b,
  output logic [7:0]  ex_imm,
  output logic [2:0]  ex_wa,
  output logic        ex_we,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [2:0]  ex_rs1,
  output logic [2:0]  ex_rs2,
  output logic [7:0]  ex_pc,
  output logic        ex_illegal,
  output logic [7:0]  stall_count
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_BEQ  = 4'h9,
    OP_JMP  = 4'hA
  } opcode_e;

  opcode_e    op;
  logic [2:0] rd, rs1, rs2;
  logic [5:0] imm6;
  logic       uses_rs1, uses_rs2;
  logic       dec_we, dec_mem_rd, dec_mem_wr, dec_branch, dec_jump, dec_illegal;
  logic       hz;

  assign op   = opcode_e'(id_instr[15:12]);
  assign rd   = id_instr[11:9];
  assign rs1  = id_instr[8:6];
  assign rs2  = id_instr[5:3];
  assign imm6 = id_instr[5:0];

  assign ra1 = rs1;
  assign ra2 = rs2;

  always_comb begin
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    dec_we      = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_we   = 1'b1;
      end
      OP_ADDI: begin
        uses_rs1 = 1'b1;
        dec_we   = 1'b1;
      end
      OP_LD: begin
        uses_rs1   = 1'b1;
        dec_we     = 1'b1;
        dec_mem_rd = 1'b1;
      end
      OP_ST: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec_mem_wr = 1'b1;
      end
      OP_BEQ: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec_branch = 1'b1;
      end
      OP_JMP: dec_jump = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign hz = id_valid & ex_valid & ex_mem_rd & (ex_wa != 3'd0) &
              ((uses_rs1 & (rs1 == ex_wa)) | (uses_rs2 & (rs2 == ex_wa)));
  assign id_stall = hz & ~flush;

  // Flush and bubble only clear validity/controls; data fields keep stale values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_wa      <= '0;
      ex_we      <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_branch  <= 1'b0;
      ex_jump    <= 1'b0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_pc      <= '0;
      ex_illegal <= 1'b0;
    end else if (flush || hz) begin
      ex_valid   <= 1'b0;
      ex_we      <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_branch  <= 1'b0;
      ex_jump    <= 1'b0;
      ex_illegal <= 1'b0;
    end else begin
      ex_valid   <= id_valid;
      ex_op      <= op;
      ex_a       <= rd1;
      ex_b       <= rd2;
      ex_imm     <= {imm6[5], imm6[5], imm6};
      ex_wa      <= rd;
      ex_we      <= id_valid & dec_we & (rd != 3'd0);
      ex_mem_rd  <= id_valid & dec_mem_rd;
      ex_mem_wr  <= id_valid & dec_mem_wr;
      ex_branch  <= id_valid & dec_branch;
      ex_jump    <= id_valid & dec_jump;
      ex_rs1     <= rs1;
      ex_rs2     <= rs2;
      ex_pc      <= id_pc;
      ex_illegal <= id_valid & dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_count <= '0;
    else if (id_stall && stall_count != 8'hFF)
      stall_count <= stall_count + 8'd1;
  end

endmodule
